// File: rtl/bcd_xs3_pkg.sv
// Shared types and constants for the BCD to Excess-3 converter.
package bcd_xs3_pkg;

  localparam int unsigned DIGIT_W = 4;

  typedef logic [DIGIT_W-1:0] digit_t;

  localparam digit_t XS3_OFFSET = 4'd3;
  localparam digit_t BCD_MAX    = 4'd9;

  // Wrapping 4-bit add; illegal digits 10..15 wrap rather than saturate.
  function automatic digit_t bcd_to_xs3(input digit_t n);
    return digit_t'(n + XS3_OFFSET);
  endfunction

endpackage

// File: rtl/bcd_xs3_core.sv
// Combinational digit mapper N -> (N + 3) mod 16.
// Optional illegal-digit flag under BCD_XS3_ERR_CHK_EN.
module bcd_xs3_core
  import bcd_xs3_pkg::*;
(
  input  logic [3:0] i_n,
  output logic [3:0] o_r
`ifdef BCD_XS3_ERR_CHK_EN
  ,
  output logic       o_err
`endif
);

  digit_t w_n;

  assign w_n = digit_t'(i_n);
  assign o_r = bcd_to_xs3(w_n);

`ifdef BCD_XS3_ERR_CHK_EN
  assign o_err = (w_n > BCD_MAX);
`endif

endmodule

// File: rtl/bcd_xs3.sv
// Registered BCD to Excess-3 converter, one digit per cycle, 1-cycle latency.
// Optional err output enabled by BCD_XS3_ERR_CHK_EN.
module bcd_xs3
  import bcd_xs3_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic in_vld,
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  output logic out_vld,
  output logic w,
  output logic x,
  output logic y,
  output logic z
`ifdef BCD_XS3_ERR_CHK_EN
  ,
  output logic err
`endif
);

  digit_t w_n;
  digit_t w_xs3;
  digit_t r_xs3;
  logic   r_vld;

  assign w_n = {a, b, c, d};

`ifdef BCD_XS3_ERR_CHK_EN
  logic w_err;
  logic r_err;

  bcd_xs3_core u_core (
    .i_n   (w_n),
    .o_r   (w_xs3),
    .o_err (w_err)
  );

  // Error flag tracks the data register: loads only on accepted digits.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (in_vld) begin
      r_err <= w_err;
    end
  end

  assign err = r_err;
`else
  bcd_xs3_core u_core (
    .i_n (w_n),
    .o_r (w_xs3)
  );
`endif

  // Data holds while in_vld is low; valid is a plain delayed copy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= 1'b0;
      r_xs3 <= '0;
    end else begin
      r_vld <= in_vld;
      if (in_vld) begin
        r_xs3 <= w_xs3;
      end
    end
  end

  assign out_vld      = r_vld;
  assign {w, x, y, z} = r_xs3;

endmodule

// File: tb/tb_bcd_xs3.sv
// Self-checking bench for bcd_xs3: directed vector table plus random stream
// compared against a behavioural model of the last accepted digit.
module tb_bcd_xs3;

  logic clk;
  logic rst;
  logic in_vld;
  logic a, b, c, d;
  logic out_vld;
  logic w, x, y, z;
`ifdef BCD_XS3_ERR_CHK_EN
  logic err;
`endif

  int errors = 0;
  int checks = 0;

  bcd_xs3 dut (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (in_vld),
    .a       (a),
    .b       (b),
    .c       (c),
    .d       (d),
    .out_vld (out_vld),
    .w       (w),
    .x       (x),
    .y       (y),
    .z       (z)
`ifdef BCD_XS3_ERR_CHK_EN
    ,
    .err     (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       vld;
    logic [3:0] n;
    logic       exp_vld;
    logic [3:0] exp_q;
    logic       exp_err;
    string      name;
  } vec_t;

  vec_t vecs[$];

  // Expected XS-3 codes for inputs 0..15, written out literally.
  logic [3:0] xs3_tab [16];

  // Reference model state: previous accepted result.
  int m_q;
  int m_vld;
  int m_err;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input logic r, input logic v, input logic [3:0] n);
    rst    = r;
    in_vld = v;
    {a, b, c, d} = n;
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs(input string name, input int e_vld, input int e_q,
                               input int e_err);
    check({name, ".vld"}, int'(out_vld), e_vld);
    check({name, ".q"}, int'({w, x, y, z}), e_q);
`ifdef BCD_XS3_ERR_CHK_EN
    check({name, ".err"}, int'(err), e_err);
`else
    if (e_err < 0) $display("unexpected negative err expectation");
`endif
  endtask

  function automatic void add(input logic r, input logic v, input logic [3:0] n,
                              input logic ev, input logic [3:0] eq, input logic ee,
                              input string name);
    vec_t t;
    t.rst = r; t.vld = v; t.n = n;
    t.exp_vld = ev; t.exp_q = eq; t.exp_err = ee; t.name = name;
    vecs.push_back(t);
  endfunction

  initial begin
    xs3_tab = '{4'b0011, 4'b0100, 4'b0101, 4'b0110, 4'b0111, 4'b1000, 4'b1001, 4'b1010,
                4'b1011, 4'b1100, 4'b1101, 4'b1110, 4'b1111, 4'b0000, 4'b0001, 4'b0010};

    rst = 1'b1; in_vld = 1'b0; {a, b, c, d} = 4'b0000;

    // Reset for two cycles with a valid digit present: must be discarded.
    add(1'b1, 1'b1, 4'b0101, 1'b0, 4'b0000, 1'b0, "reset0");
    add(1'b1, 1'b1, 4'b0101, 1'b0, 4'b0000, 1'b0, "reset1");
    // Full sweep, legal then illegal digits, back to back.
    for (int i = 0; i < 16; i++) begin
      add(1'b0, 1'b1, 4'(i), 1'b1, xs3_tab[i], (i > 9), $sformatf("sweep%0d", i));
    end
    // Hold: the second digit has in_vld low and must not load.
    add(1'b0, 1'b1, 4'b0111, 1'b1, 4'b1010, 1'b0, "hold_load");
    add(1'b0, 1'b0, 4'b0010, 1'b0, 4'b1010, 1'b0, "hold_idle");
    add(1'b0, 1'b0, 4'b1111, 1'b0, 4'b1010, 1'b0, "hold_idle2");
    // Err holds across idle cycles after an illegal digit.
    add(1'b0, 1'b1, 4'b1101, 1'b1, 4'b0000, 1'b1, "err_load");
    add(1'b0, 1'b0, 4'b0001, 1'b0, 4'b0000, 1'b1, "err_hold");
    // Reset mid-stream beats a valid 9.
    add(1'b0, 1'b1, 4'b0011, 1'b1, 4'b0110, 1'b0, "pre_rst");
    add(1'b1, 1'b1, 4'b1001, 1'b0, 4'b0000, 1'b0, "mid_rst");
    add(1'b0, 1'b0, 4'b1001, 1'b0, 4'b0000, 1'b0, "post_rst");
    add(1'b0, 1'b1, 4'b1000, 1'b1, 4'b1011, 1'b0, "first_after");

    foreach (vecs[i]) begin
      apply(vecs[i].rst, vecs[i].vld, vecs[i].n);
      check_outputs(vecs[i].name, int'(vecs[i].exp_vld), int'(vecs[i].exp_q),
                    int'(vecs[i].exp_err));
    end

    // Random stream against the model, with occasional resets.
    m_q = 11; m_vld = 1; m_err = 0;
    for (int k = 0; k < 1000; k++) begin
      int n;
      int v;
      int r;
      n = int'($urandom_range(15, 0));
      v = int'($urandom_range(1, 0));
      r = ($urandom_range(49, 0) == 0) ? 1 : 0;
      apply(r[0], v[0], 4'(n));
      if (r != 0) begin
        m_q = 0; m_vld = 0; m_err = 0;
      end else if (v != 0) begin
        m_q = (n + 3) % 16; m_vld = 1; m_err = (n > 9) ? 1 : 0;
      end else begin
        m_vld = 0;
      end
      check_outputs("rand", m_vld, m_q, m_err);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running expected done");
    $fatal(1);
  end

endmodule

// File: doc/bcd_xs3.md
# bcd_xs3

Registered 4-bit BCD to Excess-3 (XS-3) code converter. It accepts one BCD digit per cycle on four scalar bit inputs and produces the XS-3 code, which is the digit plus 3, on four scalar bit outputs one clock later. It sits as a leaf code-conversion stage in decimal datapaths that need self-complementing digit codes, for example ahead of XS-3 adders or nine's-complement logic.

## Interface
Parameters:
- None. The digit width is fixed at 4 bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  reset, synchronous and active-high
- in_vld  input  1  input digit valid qualifier
- a  input  1  BCD bit 3 (MSB, weight 8)
- b  input  1  BCD bit 2 (weight 4)
- c  input  1  BCD bit 1 (weight 2)
- d  input  1  BCD bit 0 (LSB, weight 1)
- out_vld  output  1  registered copy of in_vld
- w  output  1  XS-3 bit 3 (MSB)
- x  output  1  XS-3 bit 2
- y  output  1  XS-3 bit 1
- z  output  1  XS-3 bit 0 (LSB)
- err  output  1  input was not a legal BCD digit (only present with BCD_XS3_ERR_CHK_EN)

## Operation
- Form the input value N = {a,b,c,d}, with a as the MSB.
- Compute R = (N + 3) mod 16 as a 4-bit unsigned add. Drop the carry out.
- Present R on {w,x,y,z}, with w as the MSB.
- Legal BCD inputs 0..9 map to 3..12: 0→0011, 1→0100, 2→0101, 3→0110, 4→0111, 5→1000, 6→1001, 7→1010, 8→1011, 9→1100.
- Illegal inputs 10..15 use the same arithmetic and wrap: 10→1101, 11→1110, 12→1111, 13→0000, 14→0001, 15→0010.
- Illegal inputs are not don't-cares. The outputs must match this table exactly.
- When in_vld=1 on a clock edge, load R into the output register and set out_vld=1.
- When in_vld=0 on a clock edge:
  - hold {w,x,y,z} at their previous value;
  - set out_vld=0.
- Sustained valid input gives full throughput, one digit per cycle.
- There is no backpressure.

## Timing
- Latency: exactly 1 clock from an in_vld=1 edge to the matching out_vld=1 and result.
- Outputs are purely registered. There is no combinational path from any input to any output.
- Reset values: {w,x,y,z}=0000, out_vld=0, err=0.
- Reset takes priority over in_vld on the same edge. A digit presented in the reset cycle is discarded.
- The reset output value 0000 is not a legal XS-3 code. Consumers must qualify the outputs with out_vld.
- Back-to-back digits: each edge with in_vld=1 overwrites the previous result. No history is kept.

## Configuration
- BCD_XS3_ERR_CHK_EN defined:
  - the err port exists;
  - err is registered alongside the data and updates only when in_vld=1;
  - err=1 when N>9, else 0, and is held while in_vld=0.
  - Data outputs are unaffected by err.
- BCD_XS3_ERR_CHK_EN undefined:
  - the err port and its register are absent;
  - all other behaviour is identical.

## Structure
- Shared package bcd_xs3_pkg holds:
  - XS3_OFFSET = 4'd3;
  - BCD_MAX = 4'd9;
  - a 4-bit digit typedef used for N and R.
- One combinational sub-module, bcd_xs3_core, maps N to R (and the error bit when enabled).
- The top level holds only the valid, data and err registers and the reset logic.

## Test plan
- Reset: assert rst for 2 cycles with in_vld=1 and N=0101 → {w,x,y,z}=0000 and out_vld=0 throughout. The first output appears 1 cycle after rst falls.
- Legal sweep: N=0..9 on consecutive cycles with in_vld=1 → 0011, 0100, …, 1100, each 1 cycle later, out_vld=1, err=0.
- Illegal sweep: N=10..15 → 1101, 1110, 1111, 0000, 0001, 0010, with err=1 when the macro is enabled.
- Hold: apply N=0111 with in_vld=1, then N=0010 with in_vld=0 → outputs stay 1010 and out_vld drops to 0.
- Reset mid-stream: assert rst while in_vld=1 and N=1001 → next edge gives 0000 and out_vld=0. The 1100 result is never produced.
- Exhaustive compare: random N and random in_vld for 1000 cycles → outputs always equal the previous accepted (N+3) mod 16.
